// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Load-use / branch / multi-cycle hazard control with watchdog.
//            Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_memread,
    input  logic       ex_branch_taken,
    input  logic       ex_mc_op,
    input  logic       mc_done,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       ex_write,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic       mc_start,
    output logic       mc_abort,
    output logic       mc_busy,
    output logic       mc_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_wdog_last = 8'(MC_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    logic       w_load_use;

    assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        err_d        = err_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        ex_write     = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        mc_start     = 1'b0;
        mc_abort     = 1'b0;
        mc_busy      = 1'b0;
        // Reset forces the RUN defaults regardless of state or inputs
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (ex_mc_op) begin
                        mc_start    = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_write    = 1'b0;
                        wdog_d      = 8'd0;
                        state_d     = MC_WAIT;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    if (mc_done) begin
                        state_d = RUN;
                    end else if (wdog_q == c_wdog_last) begin
                        mc_abort = 1'b1;
                        err_d    = 1'b1;
                        state_d  = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_write    = 1'b0;
                        wdog_d      = wdog_q + 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wdog_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign mc_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (if_id_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counter width has no effect when the counters are compiled out
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
`default_nettype wire
